id_ex_stage: RTL and testbench

// - Decode-to-execute pipeline register. Captures the decoded control bundle (control_unit outputs), operands, immediate and PC.
// - Detects load-use hazards against the instruction in EX and inserts bubbles.
// - Honours flush (taken BLT/BGE/JMP) and EX-busy (multi-cycle divp) hold.
// - Keeps a saturating bubble counter for performance checks.

---
 rtl/pipeline_pkg.sv | 54 +++++
 rtl/id_ex_stage_hazard_detect.sv | 32 +++
 rtl/id_ex_stage.sv | 98 +++++++++
 tb/tb_id_ex_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: decoded control bundle, NOP encoding, ALU/funct2 codes
// and the source-operand usage rules used by hazard detection.
package pipeline_pkg;

    // Field order matches the control_unit output bundle, MSB first.
    typedef struct packed {
        logic [1:0] alu_op;
        logic       mem_to_reg;
        logic       branch;
        logic       byte_enable;
        logic       mem_read;
        logic       mem_write;
        logic       reg_src;
        logic       alu_src;
        logic       reg_write;
        logic       cmp;
        logic       blt;
        logic       bge;
        logic       jmp;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_CMP   = 2'b11;

    localparam logic [1:0] FUNCT2_ADDP = 2'b00;
    localparam logic [1:0] FUNCT2_SUBP = 2'b01;
    localparam logic [1:0] FUNCT2_MULP = 2'b10;
    localparam logic [1:0] FUNCT2_DIVP = 2'b11;

    localparam int         OPCODE_W    = 4;
    localparam logic [3:0] OPC_RTYPE   = 4'h0;
    localparam logic [3:0] OPC_ADDIP   = 4'h1;
    localparam logic [3:0] OPC_LW      = 4'h2;
    localparam logic [3:0] OPC_SW      = 4'h3;
    localparam logic [3:0] OPC_BLT     = 4'h4;
    localparam logic [3:0] OPC_BGE     = 4'h5;
    localparam logic [3:0] OPC_JMP     = 4'h6;

    // Jumps take their target from the immediate, so rs1 is never read.
    function automatic logic uses_rs1(input logic jmp);
        return ~jmp;
    endfunction

    // rs2 is read by R-type ops, stores (data) and compare-branches.
    function automatic logic uses_rs2(input logic alu_src, input logic mem_write,
                                      input logic blt, input logic bge);
        return ~alu_src | mem_write | blt | bge;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector: the instruction in ID reads the register
// that a load currently in EX will only produce after memory access.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic              id_valid,
    input  logic              id_jmp,
    input  logic              id_alu_src,
    input  logic              id_mem_write,
    input  logic              id_blt,
    input  logic              id_bge,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              lu
);

    logic ex_load;
    logic hit_rs1;
    logic hit_rs2;

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign ex_load = ex_valid & ex_mem_read & (ex_rd != '0);
    assign hit_rs1 = uses_rs1(id_jmp) & (id_rs1 == ex_rd);
    assign hit_rs2 = uses_rs2(id_alu_src, id_mem_write, id_blt, id_bge) & (id_rs2 == ex_rd);
    assign lu      = id_valid & ex_load & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion, flush, EX-busy hold
// and a saturating count of inserted bubbles.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  ctrl_t             id_ctrl_i,
    input  logic [1:0]        id_funct2_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [DATA_W-1:0] id_rd1_i,
    input  logic [DATA_W-1:0] id_rd2_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [PC_W-1:0]   id_pc_i,
    input  logic              flush_i,
    input  logic              ex_busy_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output ctrl_t             ex_ctrl_o,
    output logic [1:0]        ex_funct2_o,
    output logic [REG_AW-1:0] ex_rs1_o,
    output logic [REG_AW-1:0] ex_rs2_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [DATA_W-1:0] ex_rd1_o,
    output logic [DATA_W-1:0] ex_rd2_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [PC_W-1:0]   ex_pc_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic lu;
    logic kill;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .id_valid     (id_valid_i),
        .id_jmp       (id_ctrl_i.jmp),
        .id_alu_src   (id_ctrl_i.alu_src),
        .id_mem_write (id_ctrl_i.mem_write),
        .id_blt       (id_ctrl_i.blt),
        .id_bge       (id_ctrl_i.bge),
        .id_rs1       (id_rs1_i),
        .id_rs2       (id_rs2_i),
        .ex_valid     (ex_valid_o),
        .ex_mem_read  (ex_ctrl_o.mem_read),
        .ex_rd        (ex_rd_o),
        .lu           (lu)
    );

    // Upstream handshake: stall_o=1 means IF/ID must hold its instruction this cycle;
    // ex_valid_o=1 means EX holds a real instruction. A flush overrides both hold sources,
    // and a busy EX masks lu, which is re-evaluated once busy drops.
    assign stall_o = ~flush_i & (ex_busy_i | lu);
    assign kill    = flush_i | (~ex_busy_i & lu);

    always_ff @(posedge clk) begin
        if (!rst_n || kill) begin
            ex_valid_o  <= 1'b0;
            ex_ctrl_o   <= CTRL_NOP;
            ex_funct2_o <= '0;
            ex_rs1_o    <= '0;
            ex_rs2_o    <= '0;
            ex_rd_o     <= '0;
            ex_rd1_o    <= '0;
            ex_rd2_o    <= '0;
            ex_imm_o    <= '0;
            ex_pc_o     <= '0;
        end else if (!ex_busy_i) begin
            ex_valid_o  <= id_valid_i;
            // An empty ID slot must never carry write enables into EX.
            ex_ctrl_o   <= id_valid_i ? id_ctrl_i : CTRL_NOP;
            ex_funct2_o <= id_funct2_i;
            ex_rs1_o    <= id_rs1_i;
            ex_rs2_o    <= id_rs2_i;
            ex_rd_o     <= id_rd_i;
            ex_rd1_o    <= id_rd1_i;
            ex_rd2_o    <= id_rd2_i;
            ex_imm_o    <= id_imm_i;
            ex_pc_o     <= id_pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_o <= '0;
        end else if (kill && (bubble_cnt_o != {CNT_W{1'b1}})) begin
            bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed pipeline scenarios followed by random traffic,
// all checked against a cycle-level reference model.
module tb_id_ex_stage;
    import pipeline_pkg::*;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int REG_AW = 4;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 2;
    localparam int BW     = 1 + $bits(ctrl_t) + 2 + 3*REG_AW + 3*DATA_W + PC_W;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              id_valid;
    ctrl_t             id_ctrl;
    logic [1:0]        id_funct2;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
    logic [PC_W-1:0]   id_pc;
    logic              flush, ex_busy;

    logic              stall_a, ex_valid_a;
    ctrl_t             ex_ctrl_a;
    logic [1:0]        ex_funct2_a;
    logic [REG_AW-1:0] ex_rs1_a, ex_rs2_a, ex_rd_a;
    logic [DATA_W-1:0] ex_rd1_a, ex_rd2_a, ex_imm_a;
    logic [PC_W-1:0]   ex_pc_a;
    logic [CNT_W-1:0]  cnt_a;

    logic              stall_b, ex_valid_b;
    ctrl_t             ex_ctrl_b;
    logic [1:0]        ex_funct2_b;
    logic [REG_AW-1:0] ex_rs1_b, ex_rs2_b, ex_rd_b;
    logic [DATA_W-1:0] ex_rd1_b, ex_rd2_b, ex_imm_b;
    logic [PC_W-1:0]   ex_pc_b;
    logic [SAT_W-1:0]  cnt_b;

    id_ex_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_ctrl_i(id_ctrl),
        .id_funct2_i(id_funct2), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_rd1_i(id_rd1), .id_rd2_i(id_rd2), .id_imm_i(id_imm), .id_pc_i(id_pc),
        .flush_i(flush), .ex_busy_i(ex_busy), .stall_o(stall_a), .ex_valid_o(ex_valid_a),
        .ex_ctrl_o(ex_ctrl_a), .ex_funct2_o(ex_funct2_a), .ex_rs1_o(ex_rs1_a),
        .ex_rs2_o(ex_rs2_a), .ex_rd_o(ex_rd_a), .ex_rd1_o(ex_rd1_a), .ex_rd2_o(ex_rd2_a),
        .ex_imm_o(ex_imm_a), .ex_pc_o(ex_pc_a), .bubble_cnt_o(cnt_a)
    );

    id_ex_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_ctrl_i(id_ctrl),
        .id_funct2_i(id_funct2), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_rd1_i(id_rd1), .id_rd2_i(id_rd2), .id_imm_i(id_imm), .id_pc_i(id_pc),
        .flush_i(flush), .ex_busy_i(ex_busy), .stall_o(stall_b), .ex_valid_o(ex_valid_b),
        .ex_ctrl_o(ex_ctrl_b), .ex_funct2_o(ex_funct2_b), .ex_rs1_o(ex_rs1_b),
        .ex_rs2_o(ex_rs2_b), .ex_rd_o(ex_rd_b), .ex_rd1_o(ex_rd1_b), .ex_rd2_o(ex_rd2_b),
        .ex_imm_o(ex_imm_b), .ex_pc_o(ex_pc_b), .bubble_cnt_o(cnt_b)
    );

    logic [BW-1:0] bundle_a, bundle_b;
    assign bundle_a = {ex_valid_a, ex_ctrl_a, ex_funct2_a, ex_rs1_a, ex_rs2_a, ex_rd_a,
                       ex_rd1_a, ex_rd2_a, ex_imm_a, ex_pc_a};
    assign bundle_b = {ex_valid_b, ex_ctrl_b, ex_funct2_b, ex_rs1_b, ex_rs2_b, ex_rd_b,
                       ex_rd1_b, ex_rd2_b, ex_imm_b, ex_pc_b};

    // ---------------- reference model ----------------
    // Model of "what instruction sits in EX": a record plus a plain integer bubble tally.
    logic              m_valid;
    ctrl_t             m_ctrl;
    logic [1:0]        m_funct2;
    logic [REG_AW-1:0] m_rs1, m_rs2, m_rd;
    logic [DATA_W-1:0] m_rd1, m_rd2, m_imm;
    logic [PC_W-1:0]   m_pc;
    int                m_bubbles;
    bit                m_known = 1'b0;

    function automatic bit model_lu();
        bit reads_rs1, reads_rs2;
        if (!(id_valid && m_valid && m_ctrl.mem_read && m_rd != 0)) return 1'b0;
        reads_rs1 = !id_ctrl.jmp;
        reads_rs2 = !id_ctrl.alu_src || id_ctrl.mem_write || id_ctrl.blt || id_ctrl.bge;
        return (reads_rs1 && id_rs1 == m_rd) || (reads_rs2 && id_rs2 == m_rd);
    endfunction

    task automatic model_empty();
        m_valid = 0; m_ctrl = '0; m_funct2 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0;
    endtask

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_id(input logic v, input ctrl_t c, input logic [1:0] f2,
                          input int rs1, input int rs2, input int rd, input logic [PC_W-1:0] pc);
        id_valid  = v;
        id_ctrl   = c;
        id_funct2 = f2;
        id_rs1    = REG_AW'(rs1);
        id_rs2    = REG_AW'(rs2);
        id_rd     = REG_AW'(rd);
        id_rd1    = $urandom;
        id_rd2    = $urandom;
        id_imm    = $urandom;
        id_pc     = pc;
    endtask

    // One clock: check combinational stall, advance model, check registered outputs.
    task automatic step();
        bit lu, exp_stall;
        logic [BW-1:0] exp_b;
        int exp_cnt;
        #1;
        lu        = model_lu();
        exp_stall = !flush && (ex_busy || lu);
        if (m_known) begin
            check("stall", {255'd0, stall_a}, {255'd0, exp_stall});
            check("stall_sat", {255'd0, stall_b}, {255'd0, exp_stall});
        end
        if (!rst_n) begin
            model_empty();
            m_bubbles = 0;
            m_known   = 1'b1;
        end else if (flush || (!ex_busy && lu)) begin
            model_empty();
            m_bubbles++;
        end else if (!ex_busy) begin
            m_valid = id_valid; m_ctrl = id_valid ? id_ctrl : '0; m_funct2 = id_funct2;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm; m_pc = id_pc;
        end
        exp_q.push_back({m_valid, m_ctrl, m_funct2, m_rs1, m_rs2, m_rd, m_rd1, m_rd2, m_imm, m_pc});
        @(posedge clk);
        #1;
        exp_b = exp_q.pop_front();
        check("ex_bundle", bundle_a, exp_b);
        check("ex_bundle_sat", bundle_b, exp_b);
        exp_cnt = (m_bubbles > 65535) ? 65535 : m_bubbles;
        check("bubble_cnt", cnt_a, exp_cnt);
        exp_cnt = (m_bubbles > 3) ? 3 : m_bubbles;
        check("bubble_cnt_sat", cnt_b, exp_cnt);
    endtask

    function automatic ctrl_t c_alu();
        ctrl_t c = '0; c.alu_op = ALUOP_FUNCT; c.reg_write = 1; return c;
    endfunction
    function automatic ctrl_t c_load();
        ctrl_t c = '0; c.mem_read = 1; c.reg_write = 1; c.alu_src = 1; c.mem_to_reg = 1; return c;
    endfunction
    function automatic ctrl_t c_addi();
        ctrl_t c = '0; c.reg_write = 1; c.alu_src = 1; return c;
    endfunction
    function automatic ctrl_t c_jmp();
        ctrl_t c = '0; c.jmp = 1; c.alu_src = 1; return c;
    endfunction
    function automatic ctrl_t c_store();
        ctrl_t c = '0; c.mem_write = 1; c.alu_src = 1; return c;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [CNT_W-1:0] saved_cnt;
        rst_n = 1'b0; flush = 1'b0; ex_busy = 1'b0;
        set_id(1, c_alu(), 0, 1, 2, 3, 32'h10);

        // Reset with a valid instruction presented.
        step();
        step();
        check("reset_valid", ex_valid_a, 0);
        check("reset_ctrl", ex_ctrl_a, 0);
        check("reset_cnt", cnt_a, 0);
        check("reset_stall", stall_a, 0);
        rst_n = 1'b1;

        // addp r3,r1,r2 at pc 0x40.
        set_id(1, c_alu(), FUNCT2_ADDP, 1, 2, 3, 32'h40);
        step();
        check("pass_pc", ex_pc_a, 32'h40);
        check("pass_rd", ex_rd_a, 3);
        check("pass_valid", ex_valid_a, 1);

        // lw r5 ; addp r6,r5,r2 -> one bubble.
        set_id(1, c_load(), 0, 1, 0, 5, 32'h44);
        step();
        set_id(1, c_alu(), FUNCT2_ADDP, 5, 2, 6, 32'h48);
        #1 check("lu_stall", stall_a, 1);
        step();
        check("lu_bubble_valid", ex_valid_a, 0);
        check("lu_bubble_cnt", cnt_a, 1);
        check("lu_stall_drop", stall_a, 0);
        step();
        check("lu_enter_rd", ex_rd_a, 6);

        // lw r0 ; addp rs1=0 -> no stall.
        set_id(1, c_load(), 0, 1, 0, 0, 32'h4c);
        step();
        set_id(1, c_alu(), FUNCT2_ADDP, 0, 0, 6, 32'h50);
        #1 check("lu_r0_stall", stall_a, 0);
        step();

        // lw r5 ; addip r7,r5 -> stall.
        set_id(1, c_load(), 0, 1, 0, 5, 32'h54);
        step();
        set_id(1, c_addi(), 0, 5, 9, 7, 32'h58);
        #1 check("addip_stall", stall_a, 1);
        step();
        step();

        // lw r5 ; jmp rs1=5 -> no stall.
        set_id(1, c_load(), 0, 1, 0, 5, 32'h5c);
        step();
        set_id(1, c_jmp(), 0, 5, 9, 0, 32'h60);
        #1 check("jmp_stall", stall_a, 0);
        step();

        // lw r5 ; sw rs2=5 -> stall.
        set_id(1, c_load(), 0, 1, 0, 5, 32'h64);
        step();
        set_id(1, c_store(), 0, 1, 5, 0, 32'h68);
        #1 check("sw_stall", stall_a, 1);
        step();
        step();

        // divp in EX held busy for 4 cycles.
        set_id(1, c_alu(), FUNCT2_DIVP, 1, 2, 4, 32'h80);
        step();
        saved_cnt = cnt_a;
        ex_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_id(1, c_alu(), FUNCT2_ADDP, $urandom_range(0, 15), $urandom_range(0, 15), 8, 32'h84);
            #1 check("busy_stall", stall_a, 1);
            step();
            check("busy_hold_pc", ex_pc_a, 32'h80);
            check("busy_hold_cnt", cnt_a, saved_cnt);
        end
        ex_busy = 1'b0;

        // Flush beats both busy and a pending load-use.
        set_id(1, c_load(), 0, 1, 0, 5, 32'h90);
        step();
        set_id(1, c_alu(), FUNCT2_ADDP, 5, 2, 6, 32'h94);
        ex_busy = 1'b1; flush = 1'b1;
        saved_cnt = cnt_a;
        #1 check("flush_stall", stall_a, 0);
        step();
        check("flush_valid", ex_valid_a, 0);
        check("flush_cnt", cnt_a, saved_cnt + 1'b1);
        ex_busy = 1'b0;

        // Five more flushes: 2-bit counter sticks at 3.
        for (int i = 0; i < 5; i++) step();
        check("sat_cnt", cnt_b, 3);
        flush = 1'b0;

        // Random traffic biased towards dependencies on the register in EX.
        for (int i = 0; i < 400; i++) begin
            rst_n   = ($urandom_range(0, 79) != 0);
            flush   = ($urandom_range(0, 9) == 0);
            ex_busy = ($urandom_range(0, 6) == 0);
            set_id($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 2) == 0) ? c_load() : ctrl_t'($urandom_range(0, 32767)),
                   2'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 1) ? int'(m_rd) : $urandom_range(0, 15),
                   ($urandom_range(0, 1) == 1) ? int'(m_rd) : $urandom_range(0, 15),
                   $urandom_range(0, 7), $urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
